// File: rtl/wdog_timer.sv
// Watchdog counting core: prescaled windowed down-counter with early-warning
// interrupt, sticky reset flag and a fixed-length reset request pulse.
`timescale 1ns/1ps
module wdog_timer #(
  parameter int          WDOG_CNT   = 16,
  parameter int          PRESC_BASE = 4,
  parameter logic [7:0]  FEED_KEY   = 8'hAA,
  parameter int          RST_HOLD   = 8
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cr_reg_wdga,
  input  logic [WDOG_CNT-1:0] cr_reg_time,
  input  logic                cr_reg_ie,
  input  logic [WDOG_CNT-1:0] cfg_reg_window,
  input  logic [1:0]          cfg_reg_presc,
  input  logic [7:0]          fd_reg_feed,
  input  logic                rstflag_clr,
  output logic [WDOG_CNT-1:0] sr_reg_timer,
  output logic                sr_reg_rstflag,
  output logic                wdog_irq,
  output logic                wdog_rst_req
);

  localparam int PW = $clog2(PRESC_BASE * 8);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [PW:0]         ONE_D     = 1;
  localparam logic [PW-1:0]       ONE_P     = 1;
  localparam logic [WDOG_CNT-1:0] ONE_C     = 1;
  localparam logic [HW-1:0]       ONE_H     = 1;
  localparam logic [HW-1:0]       HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

  state_t              r_state, w_state_nxt;
  logic [WDOG_CNT-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0]       r_presc, w_presc_nxt;
  logic [HW-1:0]       r_hold, w_hold_nxt;
  logic                r_ewi, w_ewi_nxt;
  logic                r_rstflag, r_wdga_d, r_feed_d, r_irq, r_rst_req;
  logic                w_feed_match, w_feed_evt, w_arm, w_tick, w_expire;
  logic [PW:0]         w_div;
  logic [PW-1:0]       w_presc_max;

  assign w_feed_match = (fd_reg_feed == FEED_KEY);
  assign w_feed_evt   = w_feed_match & ~r_feed_d;
  assign w_arm        = cr_reg_wdga & ~r_wdga_d;
  assign w_div        = (PW + 1)'(PRESC_BASE) << cfg_reg_presc;
  assign w_presc_max  = PW'(w_div - ONE_D);
  assign w_tick       = (r_presc == w_presc_max);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_presc_nxt = r_presc;
    w_ewi_nxt   = r_ewi;
    w_hold_nxt  = r_hold;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_cnt_nxt   = cr_reg_time;
          w_presc_nxt = '0;
          w_ewi_nxt   = 1'b0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Feed outranks the tick; an early feed and a zero expiry collapse into one reset.
        if (w_feed_evt && (r_cnt > cfg_reg_window)) begin
          w_expire = 1'b1;
        end else if (w_feed_evt) begin
          w_cnt_nxt   = cr_reg_time;
          w_presc_nxt = '0;
          w_ewi_nxt   = 1'b0;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_cnt == '0) begin
            w_expire = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - ONE_C;
            if (w_cnt_nxt == ONE_C) w_ewi_nxt = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + ONE_P;
        end
        if (w_expire) begin
          w_state_nxt = S_EXPIRED;
          w_cnt_nxt   = '0;
          w_presc_nxt = '0;
          w_ewi_nxt   = 1'b0;
          w_hold_nxt  = '0;
        end
      end
      S_EXPIRED: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + ONE_H;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_presc   <= '0;
      r_hold    <= '0;
      r_ewi     <= 1'b0;
      r_rstflag <= 1'b0;
      r_wdga_d  <= 1'b0;
      r_feed_d  <= 1'b0;
      r_irq     <= 1'b0;
      r_rst_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_presc   <= w_presc_nxt;
      r_hold    <= w_hold_nxt;
      r_ewi     <= w_ewi_nxt;
      r_wdga_d  <= cr_reg_wdga;
      r_feed_d  <= w_feed_match;
      r_irq     <= w_ewi_nxt & cr_reg_ie;
      r_rst_req <= (w_state_nxt == S_EXPIRED);
      // Setting the flag wins over a same-cycle clear.
      if (w_expire)         r_rstflag <= 1'b1;
      else if (rstflag_clr) r_rstflag <= 1'b0;
    end
  end

  assign sr_reg_timer   = r_cnt;
  assign sr_reg_rstflag = r_rstflag;
  assign wdog_irq       = r_irq;
  assign wdog_rst_req   = r_rst_req;

endmodule

// File: tb/tb_wdog_timer.sv
// Bench for wdog_timer: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a behavioural model of the watchdog rules.
`timescale 1ns/1ps
module tb_wdog_timer;

  logic        pclk = 1'b0;
  logic        preset, cr_reg_wdga, cr_reg_ie, rstflag_clr;
  logic [15:0] cr_reg_time, cfg_reg_window, sr_reg_timer;
  logic [1:0]  cfg_reg_presc;
  logic [7:0]  fd_reg_feed;
  logic        sr_reg_rstflag, wdog_irq, wdog_rst_req;

  always #5 pclk = ~pclk;

  wdog_timer #(.WDOG_CNT(16), .PRESC_BASE(4), .FEED_KEY(8'hAA), .RST_HOLD(8)) dut (
    .pclk(pclk), .preset(preset), .cr_reg_wdga(cr_reg_wdga), .cr_reg_time(cr_reg_time),
    .cr_reg_ie(cr_reg_ie), .cfg_reg_window(cfg_reg_window), .cfg_reg_presc(cfg_reg_presc),
    .fd_reg_feed(fd_reg_feed), .rstflag_clr(rstflag_clr), .sr_reg_timer(sr_reg_timer),
    .sr_reg_rstflag(sr_reg_rstflag), .wdog_irq(wdog_irq), .wdog_rst_req(wdog_rst_req)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = idle, 1 = counting, 2 = reset request active.
  int m_mode, m_cnt, m_elapsed, m_left;
  bit m_ewi, m_flag, m_irq, m_wdga_d, m_feed_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fe, arm, fire;
    int div;
    fe   = (fd_reg_feed == 8'hAA) && !m_feed_d;
    arm  = cr_reg_wdga && !m_wdga_d;
    fire = 0;
    if (preset) begin
      m_mode = 0; m_cnt = 0; m_elapsed = 0; m_left = 0;
      m_ewi = 0; m_flag = 0; m_irq = 0; m_wdga_d = 0; m_feed_d = 0;
      return;
    end
    if (m_mode == 0) begin
      if (arm) begin
        m_mode = 1; m_cnt = int'(cr_reg_time); m_elapsed = 0; m_ewi = 0;
      end
    end else if (m_mode == 1) begin
      div = 4 << cfg_reg_presc;
      if (fe && m_cnt > int'(cfg_reg_window)) fire = 1;
      else if (fe) begin
        m_cnt = int'(cr_reg_time); m_elapsed = 0; m_ewi = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == div) begin
          m_elapsed = 0;
          if (m_cnt == 0) fire = 1;
          else begin
            m_cnt--;
            if (m_cnt == 1) m_ewi = 1;
          end
        end
      end
      if (fire) begin
        m_mode = 2; m_cnt = 0; m_ewi = 0; m_left = 8;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    if (fire) m_flag = 1;
    else if (rstflag_clr) m_flag = 0;
    m_irq    = m_ewi && cr_reg_ie;
    m_wdga_d = cr_reg_wdga;
    m_feed_d = (fd_reg_feed == 8'hAA);
  endtask

  task automatic step();
    @(posedge pclk);
    model_step();
    #1;
    check("timer",   32'(sr_reg_timer),   32'(m_cnt));
    check("rstflag", 32'(sr_reg_rstflag), 32'(m_flag));
    check("irq",     32'(wdog_irq),       32'(m_irq));
    check("rst_req", 32'(wdog_rst_req),   32'(m_mode == 2));
  endtask

  initial begin
    int first_irq, first_rst, rst_len, guard;
    preset = 1; cr_reg_wdga = 0; cr_reg_time = 16'd10; cr_reg_ie = 1;
    cfg_reg_window = 16'hFFFF; cfg_reg_presc = 0; fd_reg_feed = 0; rstflag_clr = 0;
    m_mode = 0; m_cnt = 0; m_elapsed = 0; m_left = 0;
    m_ewi = 0; m_flag = 0; m_irq = 0; m_wdga_d = 0; m_feed_d = 0;
    repeat (3) step();
    check("rst_timer0", 32'(sr_reg_timer), 32'd0);
    check("rst_out0", 32'({sr_reg_rstflag, wdog_irq, wdog_rst_req}), 32'd0);

    // Free-running expiry with no feed
    preset = 0; cr_reg_wdga = 1;
    first_irq = 0; first_rst = 0; rst_len = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (wdog_irq && first_irq == 0) first_irq = i;
      if (wdog_rst_req && first_rst == 0) first_rst = i;
      if (wdog_rst_req) rst_len++;
    end
    check("irq_start", 32'(first_irq), 32'd37);
    check("rst_start", 32'(first_rst), 32'd45);
    check("rst_width", 32'(rst_len), 32'd8);
    check("flag_after", 32'(sr_reg_rstflag), 32'd1);
    repeat (10) step();
    check("idle_held", 32'(sr_reg_timer), 32'd0);

    // Valid feed, held key, re-write of key
    cr_reg_wdga = 0; step();
    cr_reg_wdga = 1; step();
    guard = 0;
    while (m_cnt != 5 && guard < 200) begin step(); guard++; end
    check("reach5_bound", 32'(guard < 200), 32'd1);
    fd_reg_feed = 8'hAA; step();
    check("feed_reload", 32'(sr_reg_timer), 32'd10);
    repeat (12) step();
    check("held_no_reload", 32'(sr_reg_timer), 32'd7);
    fd_reg_feed = 8'h00; step();
    fd_reg_feed = 8'hAA; step();
    check("refeed_reload", 32'(sr_reg_timer), 32'd10);
    check("refeed_norst", 32'(wdog_rst_req), 32'd0);
    fd_reg_feed = 8'h00;

    // Early feed against a window of 3
    cfg_reg_window = 16'd3;
    guard = 0;
    while (m_cnt != 6 && guard < 200) begin step(); guard++; end
    fd_reg_feed = 8'hAA; step();
    check("early_rst", 32'(wdog_rst_req), 32'd1);
    fd_reg_feed = 8'h00;
    preset = 1; cr_reg_wdga = 0; step();
    preset = 0; cfg_reg_window = 16'hFFFF;

    // time=0, presc=3, clear strobes around the set
    cr_reg_time = 16'd0; cfg_reg_presc = 2'd3; cr_reg_wdga = 1; step();
    repeat (31) step();
    rstflag_clr = 1; step();
    check("clr_same_cycle", 32'(sr_reg_rstflag), 32'd1);
    check("t0_rst", 32'(wdog_rst_req), 32'd1);
    step();
    check("clr_late", 32'(sr_reg_rstflag), 32'd0);
    rstflag_clr = 0; preset = 1; cr_reg_wdga = 0; step();
    check("preset_mid_exp", 32'({sr_reg_timer, sr_reg_rstflag, wdog_irq, wdog_rst_req}), 32'd0);
    preset = 0; cfg_reg_presc = 0; cr_reg_time = 16'd10;

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      preset      = ($urandom % 400) == 0;
      rstflag_clr = ($urandom % 10) == 0;
      if (($urandom % 40) == 0) cr_reg_wdga = ~cr_reg_wdga;
      if (($urandom % 50) == 0) cr_reg_ie = ~cr_reg_ie;
      case ($urandom % 16)
        0:       fd_reg_feed = 8'hAA;
        1, 2:    fd_reg_feed = 8'h00;
        3:       fd_reg_feed = 8'($urandom);
        default: ;
      endcase
      if (m_mode == 0 && ($urandom % 8) == 0) begin
        cr_reg_time    = 16'($urandom % 13);
        cfg_reg_window = (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom % 12);
        cfg_reg_presc  = (($urandom % 3) == 0) ? 2'($urandom % 4) : 2'd0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
